regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the register file's single write port (WE3/A3/WD3) among NREQ writeback requesters: ALU result, load data, and multi-cycle unit results. Each requester uses a valid/ready handshake. One write is granted per cycle and presented to the register file from a registered output stage. Writes to register 0 are accepted and discarded, so $zero is never written. The block sits between the writeback sources and the register file, and drives WE3/A3/WD3 directly.

## Interface
- NREQ, 3: number of requesters (2..8)
- DW, 32: data width
- AW, 5: register address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending; must not depend combinationally on req_ready
- req_addr  in  NREQ*AW  destination register, requester i in bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i in bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot or zero; handshake for i completes on an edge where req_valid[i] and req_ready[i] are both 1
- wb_hold  in  1  when 1, no grants are issued this cycle
- WE3  out  1  register-file write enable (registered)
- A3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)
- grant_id  out  $clog2(NREQ)  index of the requester whose write is on WE3/A3/WD3 (registered)

## Operation
- State:
  - rr_ptr: the first requester searched, 0..NREQ-1
  - output registers: WE3, A3, WD3, grant_id
- Grant selection (combinational, same cycle):
  - If wb_hold=1, req_ready=0.
  - Otherwise, search i = rr_ptr, rr_ptr+1, … mod NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - At most one req_ready bit is high in any cycle.
- On an edge where a handshake completes for requester g:
  - A3 ← req_addr[g], WD3 ← req_data[g], grant_id ← g.
  - WE3 ← 1 if req_addr[g] ≠ 0, else 0. The write to $zero is dropped, but the handshake still completes.
  - rr_ptr ← (g+1) mod NREQ.
- On an edge with no handshake:
  - WE3 ← 0.
  - A3, WD3, grant_id and rr_ptr hold their values.
- No buffering inside the block. A requester holds req_valid, req_addr and req_data stable until its handshake completes.
- Fairness: a requester holding valid is granted within NREQ cycles of wb_hold being low.

## Timing
- Reset (asynchronous, while rst=1): WE3=0, A3=0, WD3=0, grant_id=0, rr_ptr=0. req_ready is then combinational from the inputs.
- If rst asserts mid-operation, any write latched in the output stage is discarded (WE3 forced to 0 immediately). Requesters must re-present their writes.
- Latency:
  - Handshake at edge t → WE3/A3/WD3 valid during cycle t..t+1.
  - The register file writes at edge t+1.
  - Consumers needing the value before edge t+1 bypass from A3/WD3 when WE3=1.
- Throughput: one write per cycle, back-to-back. No bubble between consecutive grants, including consecutive grants to the same requester.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,0,… from reset.
  - Two requesters targeting the same register in consecutive cycles: both writes are issued in grant order; the later one wins.
- wb_hold rising while a write sits in the output stage: that write still completes (WE3=1 for its cycle). Only new grants are blocked.

## Test plan
- Reset: hold rst=1 with req_valid=3'b111 → WE3=0, A3=0, WD3=0, grant_id=0. Release rst → req_ready=3'b001 in the first cycle.
- Round-robin: req_valid=3'b111 held for 6 cycles with distinct addresses 1/2/3 → grant_id sequence 0,1,2,0,1,2 on WE3 cycles. WE3=1 continuously from the second cycle.
- Single requester: only req_valid[2]=1 for 3 cycles, addr=7, data=0xDEADBEEF → WE3=1 with A3=7 and WD3=0xDEADBEEF for 3 consecutive cycles, starting one cycle after the first handshake.
- $zero drop: requester 1 with addr=0, data=0x12345678 → req_ready[1]=1 and the handshake completes, but WE3=0 the next cycle. rr_ptr still advances to 2.
- Hold: wb_hold=1 for 4 cycles with all valid → req_ready=0 and WE3=0 after the in-flight write drains. Releasing resumes at rr_ptr with no grant lost.
- Async reset mid-stream: assert rst between edges while WE3=1 → WE3 drops to 0 before the next edge. After release, rr_ptr=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port (WE3/A3/WD3)
// among NREQ writeback requesters; one grant per cycle, registered output stage.

// Per-requester eligibility: valid and at or after the round-robin pointer.
module rfwa_lane #(
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic [IW-1:0] ptr_i,
  input  logic          valid_i,
  output logic          upper_o
);
  assign upper_o = valid_i && (IW'(IDX) >= ptr_i);
endmodule

module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wb_hold,
  output logic                     WE3,
  output logic [AW-1:0]            A3,
  output logic [DW-1:0]            WD3,
  output logic [$clog2(NREQ)-1:0]  grant_id
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic [IW-1:0]   gid_q, gid_d;

  logic [NREQ-1:0] upper;
  logic [NREQ-1:0] sel;
  logic [IW-1:0]   g_idx;
  logic            found;
  logic            hs;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      rfwa_lane #(.IW(IW), .IDX(gi)) u_lane (
        .ptr_i   (rr_ptr_q),
        .valid_i (req_valid[gi]),
        .upper_o (upper[gi])
      );
    end
  endgenerate

  // Requesters at/after the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    sel   = (|upper) ? upper : req_valid;
    found = 1'b0;
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && sel[i]) begin
        found = 1'b1;
        g_idx = IW'(i);
      end
    end
  end

  assign hs = found && !wb_hold;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[g_idx] = 1'b1;
  end

  assign g_addr = req_addr[g_idx*AW +: AW];
  assign g_data = req_data[g_idx*DW +: DW];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we3_d    = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    gid_d    = gid_q;
    if (hs) begin
      // Writes to $zero still complete the handshake but never enable WE3.
      we3_d    = (g_addr != '0);
      a3_d     = g_addr;
      wd3_d    = g_data;
      gid_d    = g_idx;
      rr_ptr_d = (g_idx == IW'(NREQ-1)) ? '0 : g_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      gid_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      gid_q    <= gid_d;
    end
  end

  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a queue-free round-robin reference model.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int IW   = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                wb_hold;
  logic                WE3;
  logic [AW-1:0]       A3;
  logic [DW-1:0]       WD3;
  logic [IW-1:0]       grant_id;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  int          m_gid;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
    .WE3(WE3), .A3(A3), .WD3(WD3), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic int model_pick(int ptr, logic [NREQ-1:0] v, logic hold);
    if (hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    logic [NREQ-1:0] r;
    r = '0;
    g = model_pick(m_ptr, req_valid, wb_hold);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_a = '0; m_wd = '0; m_gid = 0;
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick(output int g);
    logic [AW-1:0] a;
    g = model_pick(m_ptr, req_valid, wb_hold);
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      m_we  = (a != '0);
      m_a   = a;
      m_wd  = req_data[g*DW +: DW];
      m_gid = g;
      m_ptr = (g + 1) % NREQ;
    end else m_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; wb_hold = 1'b0; req_valid = 3'b111;
    req_addr = '0; req_data = '0;
    model_reset();
    set_req(0, 5'd9, 32'hAAAA0000); set_req(1, 5'd10, 32'hBBBB0000); set_req(2, 5'd11, 32'hCCCC0000);
    tick(g); tick(g);
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b exp=0", WE3); end
    checks++; if (A3 !== '0) begin failures++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
    checks++; if (WD3 !== '0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", WD3); end
    checks++; if (grant_id !== '0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL reset_ready got=%b exp=001", req_ready); end
  endtask

  task automatic test_round_robin();
    int g;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1111_0001); set_req(1, 5'd2, 32'h2222_0002); set_req(2, 5'd3, 32'h3333_0003);
    for (int k = 0; k < 6; k++) begin
      tick(g);
      checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL rr_we3 cyc=%0d got=%b exp=1", k, WE3); end
      checks++; if (int'(grant_id) !== k % 3) begin failures++; $display("FAIL rr_gid cyc=%0d got=%0d exp=%0d", k, grant_id, k % 3); end
      checks++; if (A3 !== AW'(k % 3 + 1)) begin failures++; $display("FAIL rr_a3 cyc=%0d got=%0d exp=%0d", k, A3, k % 3 + 1); end
    end
  endtask

  task automatic test_single();
    int g;
    req_valid = 3'b100;
    set_req(2, 5'd7, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL single_ready got=%b exp=100", req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick(g);
      checks++; if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'hDEADBEEF || grant_id !== 2'd2) begin
        failures++;
        $display("FAIL single_write cyc=%0d got we=%b a=%0d d=%h id=%0d exp we=1 a=7 d=deadbeef id=2", k, WE3, A3, WD3, grant_id);
      end
    end
    req_valid = '0;
    tick(g);
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL single_idle_we3 got=%b exp=0", WE3); end
  endtask

  task automatic test_zero_drop();
    int g;
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'h12345678);
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL zero_ready got=%b exp=010", req_ready); end
    tick(g);
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL zero_we3 got=%b exp=0", WE3); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL zero_gid got=%0d exp=1", grant_id); end
    req_valid = 3'b111;
    set_req(0, 5'd4, 32'h4); set_req(1, 5'd5, 32'h5); set_req(2, 5'd6, 32'h6);
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL zero_ptr_adv got=%b exp=100", req_ready); end
  endtask

  task automatic test_hold();
    int g;
    logic [NREQ-1:0] er;
    tick(g);
    wb_hold = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL hold_ready got=%b exp=000", req_ready); end
    checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL hold_inflight got=%b exp=1", WE3); end
    for (int k = 0; k < 4; k++) begin
      tick(g);
      checks++; if (WE3 !== 1'b0 || req_ready !== 3'b000) begin
        failures++; $display("FAIL hold_blocked cyc=%0d got we=%b rdy=%b exp we=0 rdy=000", k, WE3, req_ready);
      end
    end
    wb_hold = 1'b0;
    #1;
    er = exp_ready();
    checks++; if (req_ready !== 3'b001 || req_ready !== er) begin failures++; $display("FAIL hold_resume got=%b exp=001 model=%b", req_ready, er); end
    tick(g);
    checks++; if (WE3 !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL hold_resume_write got we=%b id=%0d exp we=1 id=0", WE3, grant_id); end
  endtask

  task automatic test_async_reset();
    int g;
    req_valid = 3'b111;
    tick(g);
    checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b exp=1", WE3); end
    #2 rst = 1'b1;
    #1;
    checks++; if (WE3 !== 1'b0 || A3 !== '0 || WD3 !== '0 || grant_id !== '0) begin
      failures++; $display("FAIL areset_clear got we=%b a=%0d d=%h id=%0d exp all 0", WE3, A3, WD3, grant_id);
    end
    model_reset();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL areset_ptr got=%b exp=001", req_ready); end
    tick(g);
    checks++; if (WE3 !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL areset_first got we=%b id=%0d exp we=1 id=0", WE3, grant_id); end
  endtask

  task automatic test_random();
    int g;
    int waits[NREQ];
    int max_wait;
    logic [NREQ-1:0] er;
    max_wait = 0;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    req_valid = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom), $urandom);
        end
      end
      wb_hold = ($urandom_range(0, 9) == 0);
      #1;
      er = exp_ready();
      checks++; if (req_ready !== er) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); end
      tick(g);
      for (int i = 0; i < NREQ; i++) begin
        if (g == i) waits[i] = 0;
        else if (req_valid[i] && !wb_hold) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
      checks++; if (WE3 !== m_we || A3 !== m_a || WD3 !== m_wd || int'(grant_id) !== m_gid) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got we=%b a=%0d d=%h id=%0d exp we=%b a=%0d d=%h id=%0d",
                 cyc, WE3, A3, WD3, grant_id, m_we, m_a, m_wd, m_gid);
      end
      if (g >= 0) req_valid[g] = 1'b0;
    end
    checks++; if (max_wait >= NREQ) begin failures++; $display("FAIL rand_fairness got max_wait=%0d exp <%0d", max_wait, NREQ); end
    req_valid = '0; wb_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_drop();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
